// File: rtl/bp_cfg_loader.sv
// Boot-time config sequencer: streams a register table to every core, then
// releases each core's freeze register, with credit-based write flow control.
module bp_cfg_loader #(
    parameter int num_core_p       = 4,
    parameter int num_regs_p       = 8,
    parameter int cfg_addr_width_p = 16,
    parameter int cfg_data_width_p = 64,
    parameter int max_credits_p    = 4,
    parameter logic [cfg_addr_width_p-1:0] freeze_addr_p = 'h2,
    localparam int lg_num_core = (num_core_p > 1) ? $clog2(num_core_p) : 1,
    localparam int lg_num_regs = (num_regs_p > 1) ? $clog2(num_regs_p) : 1,
    localparam int cred_w      = $clog2(max_credits_p + 1)
) (
    input  logic                                       clk_i,
    input  logic                                       reset_i,
    input  logic                                       start_i,
    output logic [lg_num_regs-1:0]                     table_idx_o,
    input  logic [cfg_addr_width_p+cfg_data_width_p-1:0] table_data_i,
    output logic                                       cfg_v_o,
    input  logic                                       cfg_ready_i,
    output logic [lg_num_core-1:0]                     cfg_core_o,
    output logic [cfg_addr_width_p-1:0]                cfg_addr_o,
    output logic [cfg_data_width_p-1:0]                cfg_data_o,
    input  logic                                       ack_v_i,
    output logic                                       busy_o,
    output logic                                       done_o,
    output logic                                       err_o
);

    typedef enum logic [2:0] {
        IDLE, WRITE, DRAIN, RELEASE, DRAIN2, DONE
    } state_e;

    localparam logic [lg_num_core-1:0] last_core = lg_num_core'(num_core_p - 1);
    localparam logic [lg_num_regs-1:0] last_reg  = lg_num_regs'(num_regs_p - 1);
    localparam logic [cred_w-1:0]      max_cred  = cred_w'(max_credits_p);

    state_e                 state_q, state_d;
    logic [lg_num_core-1:0] core_q, core_d;
    logic [lg_num_regs-1:0] reg_q, reg_d;
    logic [cred_w-1:0]      credits_q;
    logic                   err_q;
    logic                   issue;
    logic                   xfer;
    logic                   start_go;

    assign issue    = (state_q == WRITE) || (state_q == RELEASE);
    // Only transfers raise credits, so a pending valid can never be withdrawn.
    assign cfg_v_o  = issue && (credits_q < max_cred);
    assign xfer     = cfg_v_o && cfg_ready_i;
    assign start_go = start_i && ((state_q == IDLE) || (state_q == DONE));

    assign busy_o      = (state_q != IDLE) && (state_q != DONE);
    assign done_o      = (state_q == DONE);
    assign err_o       = err_q;
    assign table_idx_o = reg_q;

    always_comb begin
        cfg_core_o = '0;
        cfg_addr_o = '0;
        cfg_data_o = '0;
        if (state_q == WRITE) begin
            cfg_core_o               = core_q;
            {cfg_addr_o, cfg_data_o} = table_data_i;
        end else if (state_q == RELEASE) begin
            cfg_core_o = core_q;
            cfg_addr_o = freeze_addr_p;
        end
    end

    always_comb begin
        state_d = state_q;
        core_d  = core_q;
        reg_d   = reg_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = WRITE;
                    core_d  = '0;
                    reg_d   = '0;
                end
            end
            WRITE: begin
                if (xfer) begin
                    if (reg_q == last_reg) begin
                        reg_d = '0;
                        if (core_q == last_core) begin
                            core_d  = '0;
                            state_d = DRAIN;
                        end else begin
                            core_d = core_q + 1'b1;
                        end
                    end else begin
                        reg_d = reg_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (credits_q == '0) begin
                    core_d  = '0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (xfer) begin
                    if (core_q == last_core) begin
                        core_d  = '0;
                        state_d = DRAIN2;
                    end else begin
                        core_d = core_q + 1'b1;
                    end
                end
            end
            DRAIN2: begin
                if (credits_q == '0) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            core_q  <= '0;
            reg_q   <= '0;
        end else begin
            state_q <= state_d;
            core_q  <= core_d;
            reg_q   <= reg_d;
        end
    end

    // An ack with nothing outstanding is flagged, never allowed to underflow.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            credits_q <= '0;
            err_q     <= 1'b0;
        end else if (start_go) begin
            credits_q <= '0;
            err_q     <= 1'b0;
        end else begin
            unique case ({xfer, ack_v_i})
                2'b10: credits_q <= credits_q + 1'b1;
                2'b01: begin
                    if (credits_q == '0) err_q <= 1'b1;
                    else credits_q <= credits_q - 1'b1;
                end
                default: credits_q <= credits_q;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_cfg_loader.sv
// Scoreboard bench for bp_cfg_loader: a reference write list is queued per
// start and a negedge monitor pops and compares each transfer.
module tb_bp_cfg_loader;

    localparam int NC = 2;
    localparam int NR = 3;
    localparam int MC = 2;
    localparam int AW = 16;
    localparam int DW = 64;
    localparam logic [AW-1:0] FRZ = 16'h0002;

    typedef struct packed {
        logic [0:0]    core;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic             clk = 1'b0;
    logic             reset_i = 1'b1;
    logic             start_i = 1'b0;
    logic [1:0]       table_idx_o;
    logic [AW+DW-1:0] table_data_i;
    logic             cfg_v_o;
    logic             cfg_ready_i = 1'b1;
    logic [0:0]       cfg_core_o;
    logic [AW-1:0]    cfg_addr_o;
    logic [DW-1:0]    cfg_data_o;
    logic             ack_v_i = 1'b0;
    logic             busy_o;
    logic             done_o;
    logic             err_o;

    logic [AW+DW-1:0] tbl [4];
    assign table_data_i = tbl[table_idx_o];

    int  checks = 0;
    int  errors = 0;
    int  xfer_cnt = 0;
    int  ack_cnt = 0;
    bit  ack_en = 1'b1;
    bit  man_ack = 1'b0;
    wr_t exp_q [$];

    bp_cfg_loader #(
        .num_core_p      (NC),
        .num_regs_p      (NR),
        .cfg_addr_width_p(AW),
        .cfg_data_width_p(DW),
        .max_credits_p   (MC),
        .freeze_addr_p   (FRZ)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .table_idx_o (table_idx_o),
        .table_data_i(table_data_i),
        .cfg_v_o     (cfg_v_o),
        .cfg_ready_i (cfg_ready_i),
        .cfg_core_o  (cfg_core_o),
        .cfg_addr_o  (cfg_addr_o),
        .cfg_data_o  (cfg_data_o),
        .ack_v_i     (ack_v_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] got,
                         input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: core-major walk of the table, then one freeze write per core.
    task automatic build_seq();
        for (int r = 0; r < NR; r++)
            tbl[r] = {16'($urandom), $urandom, $urandom};
        for (int c = 0; c < NC; c++)
            for (int r = 0; r < NR; r++)
                exp_q.push_back('{1'(c), tbl[r][AW+DW-1:DW], tbl[r][DW-1:0]});
        for (int c = 0; c < NC; c++)
            exp_q.push_back('{1'(c), FRZ, 64'h0});
    endtask

    task automatic pulse_start(input bit push);
        if (push) build_seq();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input bit rnd);
        int n = 0;
        while (!done_o && n < 400) begin
            if (rnd) begin
                cfg_ready_i = ($urandom_range(0, 3) != 0);
                ack_en      = 1'($urandom_range(0, 1));
            end
            tick();
            n++;
        end
        cfg_ready_i = 1'b1;
        ack_en      = 1'b1;
        check("done_timeout", done_o, 1'b1);
    endtask

    task automatic end_checks(input int x0, input int n);
        check("end_done", done_o, 1'b1);
        check("end_busy", busy_o, 1'b0);
        check("end_err", err_o, 1'b0);
        check("end_queue_empty", exp_q.size(), 0);
        check("end_write_count", xfer_cnt - x0, n);
    endtask

    initial begin : monitor
        wr_t got;
        wr_t want;
        wr_t held;
        bit  hold;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            got = '{cfg_core_o, cfg_addr_o, cfg_data_o};
            if (reset_i) begin
                exp_q.delete();
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("hold_valid", cfg_v_o, 1'b1);
                    check("hold_payload", got, held);
                end
                if (cfg_v_o && cfg_ready_i) begin
                    xfer_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got %0h, none expected", got);
                    end else begin
                        want = exp_q.pop_front();
                        check("write", got, want);
                    end
                end
                hold = cfg_v_o && !cfg_ready_i;
                held = got;
            end
        end
    end

    // Each accepted write is acked one cycle later while ack_en is set.
    initial begin : acker
        forever begin
            @(posedge clk);
            #2;
            if (reset_i) begin
                ack_cnt = xfer_cnt;
                ack_v_i = 1'b0;
            end else begin
                ack_v_i = man_ack || (ack_en && xfer_cnt > ack_cnt);
                if (ack_v_i && xfer_cnt > ack_cnt) ack_cnt++;
            end
        end
    end

    initial begin : stim
        int x0;
        wr_t held;
        for (int i = 0; i < 4; i++) tbl[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", cfg_v_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_payload", {cfg_core_o, cfg_addr_o, cfg_data_o}, 0);
        reset_i = 1'b0;
        tick();

        x0 = xfer_cnt;
        pulse_start(1'b1);
        check("busy_running", busy_o, 1'b1);
        wait_done(1'b0);
        end_checks(x0, 8);

        // Credit exhaustion, single-ack release, then ack+transfer together.
        ack_en = 1'b0;
        x0 = xfer_cnt;
        pulse_start(1'b1);
        repeat (6) tick();
        check("withheld_count", xfer_cnt - x0, 2);
        check("withheld_valid", cfg_v_o, 1'b0);
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        check("one_ack_valid", cfg_v_o, 1'b1);
        repeat (4) tick();
        check("one_ack_count", xfer_cnt - x0, 3);
        check("one_ack_revalid", cfg_v_o, 1'b0);
        cfg_ready_i = 1'b0;
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        tick();
        cfg_ready_i = 1'b1;
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        repeat (4) tick();
        check("same_cycle_count", xfer_cnt - x0, 5);
        check("same_cycle_valid", cfg_v_o, 1'b0);
        ack_en = 1'b1;
        wait_done(1'b0);
        end_checks(x0, 8);

        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        repeat (2) tick();
        check("spurious_err", err_o, 1'b1);
        check("spurious_done", done_o, 1'b1);
        ack_en = 1'b0;
        x0 = xfer_cnt;
        pulse_start(1'b1);
        check("start_clears_err", err_o, 1'b0);
        check("start_clears_done", done_o, 1'b0);
        repeat (6) tick();
        check("spurious_credits", xfer_cnt - x0, 2);
        ack_en = 1'b1;
        wait_done(1'b0);
        end_checks(x0, 8);

        cfg_ready_i = 1'b0;
        x0 = xfer_cnt;
        pulse_start(1'b1);
        check("zero_latency_valid", cfg_v_o, 1'b1);
        held = '{cfg_core_o, cfg_addr_o, cfg_data_o};
        check("first_payload", held, {1'b0, tbl[0]});
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", cfg_v_o, 1'b1);
            check("stall_payload", {cfg_core_o, cfg_addr_o, cfg_data_o}, held);
        end
        cfg_ready_i = 1'b1;
        tick();
        check("stall_release", xfer_cnt - x0, 1);
        wait_done(1'b0);
        end_checks(x0, 8);

        x0 = xfer_cnt;
        pulse_start(1'b1);
        repeat (2) tick();
        pulse_start(1'b0);
        wait_done(1'b0);
        end_checks(x0, 8);

        for (int s = 0; s < 5; s++) begin
            x0 = xfer_cnt;
            pulse_start(1'b1);
            wait_done(1'b1);
            end_checks(x0, 8);
        end

        // Abandon mid-WRITE at (core 1, reg 1), then replay from scratch.
        x0 = xfer_cnt;
        pulse_start(1'b1);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cfg_v_o && cfg_core_o == 1'b1 && table_idx_o == 2'd1) break;
        end
        check("reached_c1r1", {cfg_v_o, cfg_core_o, table_idx_o}, {1'b1, 1'b1, 2'd1});
        #2;
        reset_i = 1'b1;
        #1;
        check("async_rst_valid", cfg_v_o, 1'b0);
        check("async_rst_busy", busy_o, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset_i = 1'b0;
        tick();
        x0 = xfer_cnt;
        pulse_start(1'b1);
        wait_done(1'b0);
        end_checks(x0, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_cfg_loader.md
Name: bp_cfg_loader

Overview:
- Boot-time configuration sequencer that walks a register table and programs every core tile over the config link.
- Writes each table entry to each core, drains outstanding acks, then writes the freeze-release register per core.
- Generalises the static, package-level processor configuration into a runtime-programmed, multi-core, credit-flow-controlled loader.
- Sits between the I/O complex and the per-core cfg_bus endpoints.

Parameters:
- num_core_p, 4, cores to program; lg_num_core = max(1, clog2(num_core_p)).
- num_regs_p, 8, table entries per core; lg_num_regs = max(1, clog2(num_regs_p)).
- cfg_addr_width_p, 16, config register address width.
- cfg_data_width_p, 64, config register data width.
- max_credits_p, 4, maximum unacked writes in flight; counter width clog2(max_credits_p+1).
- freeze_addr_p, 16'h0002, address of the freeze register written during the release phase.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  one-cycle start pulse.
- table_idx_o  out  lg_num_regs  table read index.
- table_data_i  in  cfg_addr_width_p+cfg_data_width_p  {addr, data} at table_idx_o, combinational, same cycle.
- cfg_v_o  out  1  write valid.
- cfg_ready_i  in  1  write ready; a write transfers on cfg_v_o & cfg_ready_i.
- cfg_core_o  out  lg_num_core  destination core.
- cfg_addr_o  out  cfg_addr_width_p  register address.
- cfg_data_o  out  cfg_data_width_p  register data.
- ack_v_i  in  1  one write acknowledged (one credit returned).
- busy_o  out  1  sequence in progress.
- done_o  out  1  sticky completion flag.
- err_o  out  1  sticky error flag: ack received with zero credits outstanding.

Behaviour:
- Reset (async): state=IDLE, core/reg/credit counters=0, busy_o=0, done_o=0, err_o=0, cfg_v_o=0 immediately. All other outputs are 0.
- FSM states: IDLE, WRITE, DRAIN, RELEASE, DRAIN2, DONE.
- IDLE: on start_i go to WRITE, clear done_o and err_o, zero counters. busy_o=1 in every state except IDLE and DONE.
- WRITE:
  - table_idx_o=reg, cfg_core_o=core, {cfg_addr_o,cfg_data_o}=table_data_i.
  - cfg_v_o = (credits < max_credits_p).
  - On transfer, reg increments. At reg=num_regs_p-1, reg wraps to 0 and core increments.
  - The transfer of (core=num_core_p-1, reg=num_regs_p-1) moves to DRAIN.
  - Order is core-major: all registers of core 0, then core 1, and so on.
- DRAIN: cfg_v_o=0. When credits==0, set core=0 and go to RELEASE.
- RELEASE:
  - cfg_addr_o=freeze_addr_p, cfg_data_o=0, cfg_core_o=core.
  - Same credit gating as WRITE.
  - Transfer increments core. The transfer for the last core moves to DRAIN2.
- DRAIN2: when credits==0, go to DONE.
- DONE: done_o=1, busy_o=0. start_i restarts the sequence exactly as from IDLE.
- Valid/payload stability:
  - Once cfg_v_o=1 it stays 1 with a stable payload until the transfer completes.
  - Credits never increase while valid is pending, so the gate cannot drop valid.
  - table_data_i must be stable while table_idx_o is unchanged.
- Credit counter:
  - +1 on transfer, -1 on ack_v_i. A transfer and an ack in the same cycle leave it unchanged.
  - ack_v_i with credits==0 and no transfer that cycle: counter stays 0, err_o set. The FSM continues.
- Throughput: one write per cycle while credits are available and ready is high. Zero-latency issue from WRITE entry.
- start_i while busy_o=1 is ignored.
- Reset mid-sequence abandons the sequence with no further cfg_v_o. Acks arriving after reset are treated per the zero-credit rule once running.
- Degenerate num_core_p=1 or num_regs_p=1: counters are 1 bit wide and hold 0. Wrap logic must still terminate correctly.

Test Plan:
- num_core_p=2, num_regs_p=3, max_credits_p=2, ready=1, ack 1 cycle after each transfer; pulse start -> writes (c0,r0..r2),(c1,r0..r2), then freeze writes to c0 and c1 with data 0. done_o rises after the last ack; 8 transfers total.
- Same config, acks withheld -> exactly 2 transfers, then cfg_v_o=0. Releasing one ack -> exactly one more transfer the next cycle.
- cfg_ready_i low for 5 cycles with valid high -> cfg_v_o and payload held constant for all 5 cycles; transfer on the ready rising cycle.
- Transfer and ack in the same cycle with credits=1 -> credits stay 1. Spurious ack in IDLE -> err_o=1, credits stay 0.
- Assert reset_i mid-WRITE (core 1, reg 1) -> cfg_v_o=0 and busy_o=0 without a clock edge. A new start replays the full sequence from (c0,r0).
- start_i pulsed during WRITE -> no restart and order unchanged. start_i in DONE -> done_o clears and a second full sequence is issued.
